// File: rtl/split_check_sched_pkg.sv
// Split-check scheduler shared types.
// FSM state encoding and default sizing constants.
package split_check_sched_pkg;

  localparam int NUM_SPLITS_DEF = 16;
  localparam int TIMEOUT_DEF    = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/split_next_idx.sv
// Next-set-bit search over a mask.
// Finds the lowest set bit at/above 0 or strictly above i_cur.
module split_next_idx #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_cur,
  input  logic         i_incl,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // scan high-to-low so the lowest qualifying bit wins
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_incl || (i > int'(i_cur)))) begin
        o_found = 1'b1;
        o_idx   = i[W-1:0];
      end
    end
  end

endmodule

// File: rtl/split_check_sched.sv
// Split-check scheduler top.
// Sweeps masked evaluators one at a time, collecting verdicts.
module split_check_sched
  import split_check_sched_pkg::*;
#(
  parameter int NUM_SPLITS = NUM_SPLITS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_SPLITS-1:0]         cfg_mask,
  output logic [$clog2(NUM_SPLITS)-1:0] sel,
  output logic                          req_valid,
  input  logic                          rsp_valid,
  input  logic                          rsp_x,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_SPLITS-1:0]         verdict,
  output logic                          all_sat,
  output logic                          timeout_err
);

  localparam int SW = $clog2(NUM_SPLITS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_SPLITS-1:0] r_mask;
  logic [NUM_SPLITS-1:0] r_verdict;
  logic [SW-1:0]         r_sel;
  logic [TW-1:0]         r_timer;
  logic                  r_all_sat;
  logic                  r_tmo_err;

  logic [NUM_SPLITS-1:0] w_srch_mask;
  logic                  w_incl;
  logic                  w_found;
  logic [SW-1:0]         w_nidx;
  logic                  w_tmo_hit;
  logic                  w_adv;
  logic                  w_to;
  logic [NUM_SPLITS-1:0] w_verdict_nxt;

  // in IDLE search the incoming mask from bit 0, else above sel
  assign w_incl      = (r_state == IDLE);
  assign w_srch_mask = w_incl ? cfg_mask : r_mask;

  split_next_idx #(
    .N(NUM_SPLITS),
    .W(SW)
  ) u_next (
    .i_mask (w_srch_mask),
    .i_cur  (r_sel),
    .i_incl (w_incl),
    .o_found(w_found),
    .o_idx  (w_nidx)
  );

  // a response wins over a timeout landing in the same cycle
  assign w_tmo_hit = (r_timer == TMAX);
  assign w_adv = (r_state == WAIT) && (rsp_valid || w_tmo_hit);
  assign w_to  = (r_state == WAIT) && !rsp_valid && w_tmo_hit;

  // verdict with the current evaluator's result folded in
  always_comb begin
    w_verdict_nxt        = r_verdict;
    w_verdict_nxt[r_sel] = rsp_valid & rsp_x;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state and state-decoded strobes
  always_comb begin
    w_state_nxt = r_state;
    req_valid   = 1'b0;
    done        = 1'b0;
    busy        = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (cfg_mask != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        req_valid   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_adv) begin
          w_state_nxt = w_found ? ISSUE : DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // sweep datapath: mask, index, timer, results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask    <= '0;
      r_verdict <= '0;
      r_sel     <= '0;
      r_timer   <= '0;
      r_all_sat <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mask    <= cfg_mask;
            r_verdict <= '0;
            r_tmo_err <= 1'b0;
            r_all_sat <= (cfg_mask == '0);
            if (cfg_mask != '0) r_sel <= w_nidx;
          end
        end
        ISSUE: begin
          r_timer <= '0;
        end
        WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_adv) begin
            r_verdict <= w_verdict_nxt;
            if (w_to) r_tmo_err <= 1'b1;
            if (w_found) r_sel <= w_nidx;
            else r_all_sat <= &(w_verdict_nxt | ~r_mask);
          end
        end
        DONE: begin
        end
      endcase
    end
  end

  assign sel         = r_sel;
  assign verdict     = r_verdict;
  assign all_sat     = r_all_sat;
  assign timeout_err = r_tmo_err;

endmodule
